sync_fifo: RTL and testbench

Parametrised single-clock FIFO, successor to the basic `fifo` block: arbitrary (non-power-of-two) depth, fill-level reporting, programmable almost-full/almost-empty flags, synchronous flush, and push-while-full when a pop is accepted in the same cycle. It sits between producer/consumer pipeline stages in the fabric wherever buffering plus back-pressure hints are needed, and is drop-in compatible with `fifo` on the shared ports.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ram.sv | 48 ++++
 rtl/sync_fifo.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared parameter defaults and helper functions for sync_fifo
// and fifo_ram.
//   level_width(size)  : bits needed for a fill level from 0 to size.
//   ptr_inc(ptr, size) : index increment that wraps from size-1 back to 0,
//                        using an explicit compare so any depth works.
package fifo_pkg;

  localparam int unsigned SizeDefault         = 32'd10;
  localparam int unsigned EntrySizeDefault    = 32'd8;
  localparam int unsigned AlmostEmptyDefault  = 32'd2;

  function automatic int unsigned level_width(input int unsigned size);
    return $clog2(size + 32'd1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    int unsigned nxt;
    if (ptr == size - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: Size x EntrySize storage with one synchronous write port and one
// registered read port.
//   clk_i    : clock, posedge
//   rst_i    : synchronous active-high reset, clears the read register only
//   we_i     : write enable; waddr_i/wdata_i sampled at posedge
//   re_i     : read enable; rdata_o loads mem[raddr_i] at posedge
//   rdata_o  : registered read data, holds while re_i is low
// A read and a write to the same address in one cycle returns the old
// contents, which lets a full FIFO pop its head while refilling that slot.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned Size      = SizeDefault,
  parameter int unsigned EntrySize = EntrySizeDefault,
  parameter int unsigned PtrW      = $clog2(Size)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [PtrW-1:0]      waddr_i,
  input  logic [EntrySize-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [PtrW-1:0]      raddr_i,
  output logic [EntrySize-1:0] rdata_o
);

  logic [EntrySize-1:0] mem_q [Size];
  logic [EntrySize-1:0] rdata_q;

  // Storage array write port (contents are not reset).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {EntrySize{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of any depth >= 2 with fill level,
// almost-full/almost-empty flags, synchronous flush and push-while-full
// when a pop is accepted in the same cycle.
//   clk_i, rst_i         : clock and synchronous active-high reset
//   flush_i              : empties the FIFO, requests in that cycle ignored
//   write_req_i, data_i  : push request and data
//   write_valid_o        : not full
//   read_req_i, data_o   : pop request and registered popped entry
//   read_valid_o         : not empty
//   level_o              : current entry count
//   almost_full_o/_empty : level >= AlmostFullThreshold / <= AlmostEmptyThreshold
//   overflow_o/underflow_o : sticky error flags, present only when the
//                          SYNC_FIFO_ERR_FLAGS_EN macro is defined, else 0
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned Size                 = SizeDefault,
  parameter int unsigned EntrySize            = EntrySizeDefault,
  parameter int unsigned AlmostFullThreshold  = Size - 32'd2,
  parameter int unsigned AlmostEmptyThreshold = AlmostEmptyDefault
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       write_req_i,
  output logic                       write_valid_o,
  input  logic [EntrySize-1:0]       data_i,
  input  logic                       read_req_i,
  output logic                       read_valid_o,
  output logic [EntrySize-1:0]       data_o,
  output logic [$clog2(Size+1)-1:0]  level_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned LvlW = level_width(Size);
  localparam int unsigned PtrW = $clog2(Size);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            write_valid_q, write_valid_d;
  logic            read_valid_q, read_valid_d;
  logic            almost_full_q, almost_full_d;
  logic            almost_empty_q, almost_empty_d;
  logic            pop_s, push_s;

  // Handshake decode plus next-state for pointers, level and status flags.
  always_comb begin
    pop_s  = read_req_i && read_valid_q;
    // A full FIFO still accepts a push when the head is leaving this cycle.
    push_s = write_req_i && (write_valid_q || pop_s);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush_i) begin
      wr_ptr_d = {PtrW{1'b0}};
      rd_ptr_d = {PtrW{1'b0}};
      level_d  = {LvlW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = PtrW'(ptr_inc(32'(wr_ptr_q), Size));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = PtrW'(ptr_inc(32'(rd_ptr_q), Size));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + {{(LvlW-1){1'b0}}, 1'b1};
        2'b01:   level_d = level_q - {{(LvlW-1){1'b0}}, 1'b1};
        default: level_d = level_q;
      endcase
    end

    // Status is computed from the next level so the registered flags always
    // match the registered level.
    write_valid_d  = (level_d != LvlW'(Size));
    read_valid_d   = (level_d != {LvlW{1'b0}});
    almost_full_d  = (level_d >= LvlW'(AlmostFullThreshold));
    almost_empty_d = (level_d <= LvlW'(AlmostEmptyThreshold));
  end

  // Pointer, level and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= {PtrW{1'b0}};
      rd_ptr_q       <= {PtrW{1'b0}};
      level_q        <= {LvlW{1'b0}};
      write_valid_q  <= 1'b1;
      read_valid_q   <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      write_valid_q  <= write_valid_d;
      read_valid_q   <= read_valid_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Flush blocks storage access so data_o holds through it.
  fifo_ram #(
    .Size      (Size),
    .EntrySize (EntrySize),
    .PtrW      (PtrW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (push_s && !flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (pop_s && !flush_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_o)
  );

  assign write_valid_o  = write_valid_q;
  assign read_valid_o   = read_valid_q;
  assign level_o        = level_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flag next-state; flush clears them.
  always_comb begin
    if (flush_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q  | (write_req_i & ~push_s);
      underflow_d = underflow_q | (read_req_i & ~read_valid_q);
    end
  end

  // Sticky error flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo with default parameters (Size 10,
// 8-bit entries, thresholds 8 and 2). The driver applies requests at the
// falling edge and advances a queue-based reference model; each accepted
// pop pushes its expected data into a scoreboard queue. A monitor samples
// the DUT 1 time unit after each rising edge, pops the scoreboard when an
// entry is due and compares data and all status outputs with the model.
module tb_sync_fifo;

  localparam int SIZE = 10;
  localparam int AF   = SIZE - 2;
  localparam int AE   = 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0, flush_i = 1'b0;
  logic       write_req_i = 1'b0, read_req_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       write_valid_o, read_valid_o;
  logic [7:0] data_o;
  logic [3:0] level_o;
  logic       almost_full_o, almost_empty_o, overflow_o, underflow_o;

  sync_fifo dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .write_req_i    (write_req_i),
    .write_valid_o  (write_valid_o),
    .data_i         (data_i),
    .read_req_i     (read_req_i),
    .read_valid_o   (read_valid_o),
    .data_o         (data_o),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_hold;
  bit         m_ovf, m_unf;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of requests and advance the model to the post-edge state.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d,
                      input bit fl = 1'b0, input bit rs = 1'b0);
    bit pop, push;
    write_req_i = wr;
    read_req_i  = rd;
    data_i      = d;
    flush_i     = fl;
    rst_i       = rs;
    if (rs) begin
      m_q.delete();
      exp_q.delete();
      exp_q.push_back(8'h00);
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (fl) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop  = rd && (m_q.size() != 0);
      push = wr && ((m_q.size() != SIZE) || pop);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (wr && !push) m_ovf = 1'b1;
      if (rd && m_q.size() == 0) m_unf = 1'b1;
`endif
      if (pop) exp_q.push_back(m_q.pop_front());
      if (push) m_q.push_back(d);
    end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: compare DUT against model just after every rising edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) m_hold = exp_q.pop_front();
      chk("data_o", int'(data_o), int'(m_hold));
      chk("level_o", int'(level_o), m_q.size());
      chk("read_valid_o", int'(read_valid_o), int'(m_q.size() != 0));
      chk("write_valid_o", int'(write_valid_o), int'(m_q.size() != SIZE));
      chk("almost_full_o", int'(almost_full_o), int'(m_q.size() >= AF));
      chk("almost_empty_o", int'(almost_empty_o), int'(m_q.size() <= AE));
      chk("overflow_o", int'(overflow_o), int'(m_ovf));
      chk("underflow_o", int'(underflow_o), int'(m_unf));
    end
  end

  initial begin
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    // single push/pop
    step(1'b1, 1'b0, 8'hAB);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    // fill 0..9, then extra push while full, then drain
    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < SIZE; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    // full with simultaneous push/pop, then drain
    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < SIZE; i++) step(1'b0, 1'b1, 8'h00);
    // empty push+pop: pop rejected, push accepted
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    // streaming at level 1 across pointer wrap
    step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i < SIZE; i++) step(1'b1, 1'b1, 8'(i));
    step(1'b0, 1'b1, 8'h00);
    // flush with pending requests, flags cleared, data_o held
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    step(1'b1, 1'b1, 8'h99, 1'b1);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    // reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h12);
    step(1'b0, 1'b1, 8'h00);
    // randomized traffic with phase-biased fill and occasional flush/reset
    for (int ph = 0; ph < 30; ph++) begin
      int wp;
      wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      for (int c = 0; c < 80; c++) begin
        bit w, r, f, s;
        w = ($urandom_range(99) < wp);
        r = ($urandom_range(99) < (100 - wp));
        f = ($urandom_range(199) == 0);
        s = ($urandom_range(399) == 0);
        step(w, r, 8'($urandom), f, s);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
